ssemi_adc_csr_master: RTL

CSR initiator that drives the decimator's CSR write and read ports (the responder side) from a simple host command/response channel. It accepts one command at a time: write or read, 8-bit address, 32-bit data. It converts the command into the decimator's valid/ready CSR handshake, guards each transaction with a timeout, and returns one response per command. It sits between the system config bus bridge and ssemi_adc_decimator_top_wrapper.

---
 rtl/ssemi_adc_csr_master.sv | 110 +++++++++++
 1 files changed

// File: rtl/ssemi_adc_csr_master.sv
// CSR initiator: turns one host command at a time into the decimator's CSR
// valid/ready handshake, with a per-transaction timeout and one response per command.
module ssemi_adc_csr_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_write,
  input  logic [7:0]  i_cmd_addr,
  input  logic [31:0] i_cmd_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_error,
  output logic        o_csr_wr_valid,
  output logic [7:0]  o_csr_addr,
  output logic [31:0] o_csr_wr_data,
  input  logic        i_csr_wr_ready,
  output logic        o_csr_rd_ready,
  input  logic [31:0] i_csr_rd_data,
  input  logic        i_csr_rd_valid,
  output logic        o_busy,
  output logic [7:0]  o_timeout_count
);

  typedef enum logic [1:0] {StIdle, StWr, StRd, StResp} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [7:0]        addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              error_q;
  logic [7:0]        tmo_cnt_q;
  logic              cnt_last;

  assign cnt_last = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_cmd_valid) begin
            addr_q  <= i_cmd_addr;
            wdata_q <= i_cmd_wdata;
            cnt_q   <= '0;
            state_q <= i_cmd_write ? StWr : StRd;
          end
        end
        StWr: begin
          // A handshake on the final timeout cycle still counts as success.
          if (i_csr_wr_ready || cnt_last) begin
            error_q <= !i_csr_wr_ready;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            state_q <= StResp;
            if (!i_csr_wr_ready && tmo_cnt_q != 8'hff) tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRd: begin
          if (i_csr_rd_valid || cnt_last) begin
            error_q <= !i_csr_rd_valid;
            rdata_q <= i_csr_rd_valid ? i_csr_rd_data : 32'h0;
            addr_q  <= '0;
            wdata_q <= '0;
            state_q <= StResp;
            if (!i_csr_rd_valid && tmo_cnt_q != 8'hff) tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          if (i_rsp_ready) begin
            rdata_q <= '0;
            error_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // All outputs are decodes of registered state only; no input reaches an output.
  assign o_cmd_ready     = (state_q == StIdle);
  assign o_busy          = (state_q != StIdle);
  assign o_csr_wr_valid  = (state_q == StWr);
  assign o_csr_rd_ready  = (state_q == StRd);
  assign o_rsp_valid     = (state_q == StResp);
  assign o_csr_addr      = addr_q;
  assign o_csr_wr_data   = wdata_q;
  assign o_rsp_rdata     = rdata_q;
  assign o_rsp_error     = error_q;
  assign o_timeout_count = tmo_cnt_q;

endmodule
